// File: rtl/alu_pkg.sv
// Shared opcodes, status bit positions and FSM encodings for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MUL  = 4'b0011;
    localparam logic [3:0] ALU_DIV  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    localparam int unsigned STATUS_W = 8;
    localparam int unsigned ST_ZERO  = 0;
    localparam int unsigned ST_NEG   = 1;
    localparam int unsigned ST_CARRY = 2;
    localparam int unsigned ST_OVF   = 3;
    localparam int unsigned ST_DZ    = 4;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    typedef enum logic {MODE_MUL, MODE_DIV} md_mode_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/result handshake bundle between issue, the ALU and writeback.
interface seq_alu_if #(parameter int unsigned WIDTH = 32);

    logic                          in_valid;
    logic                          in_ready;
    logic [3:0]                    alu_control;
    logic [WIDTH-1:0]              alu_operand_1;
    logic [WIDTH-1:0]              alu_operand_2;
    logic                          out_valid;
    logic                          out_ready;
    logic [WIDTH-1:0]              alu_result;
    logic [WIDTH-1:0]              alu_result_hi;
    logic [alu_pkg::STATUS_W-1:0]  alu_status;

    modport master (
        output in_valid, alu_control, alu_operand_1, alu_operand_2, out_ready,
        input  in_ready, out_valid, alu_result, alu_result_hi, alu_status
    );

    modport slave (
        input  in_valid, alu_control, alu_operand_1, alu_operand_2, out_ready,
        output in_ready, out_valid, alu_result, alu_result_hi, alu_status
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Bit-serial engine: shift-add multiply (LSB first) or restoring divide (MSB first),
// one bit per clock on a shared {hi, lo} accumulator.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  md_mode_t         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] b_q;
    md_mode_t         mode_q;
    logic             busy_q;
    logic             dz_q;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   shl_w;
    logic             qbit;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // One iteration step for the active mode
    always_comb begin
        add_w = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        shl_w = {hi, lo[WIDTH-1]};
        qbit  = (shl_w >= {1'b0, b_q});
        hi_n  = hi;
        lo_n  = lo;
        if (mode_q == MODE_MUL) begin
            hi_n = add_w[WIDTH:1];
            lo_n = {add_w[0], lo[WIDTH-1:1]};
        end else begin
            hi_n = qbit ? WIDTH'(shl_w - {1'b0, b_q}) : shl_w[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], qbit};
        end
    end

    // A zero divisor skips iteration entirely and reports done on its first busy cycle
    assign done = busy_q & (dz_q | (cnt_q == CNT_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            b_q    <= '0;
            mode_q <= MODE_MUL;
            busy_q <= 1'b0;
            dz_q   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(WIDTH);
            mode_q <= mode;
            b_q    <= b;
            if ((mode == MODE_DIV) && (b == '0)) begin
                dz_q <= 1'b1;
                hi   <= a;
                lo   <= '1;
            end else begin
                dz_q <= 1'b0;
                hi   <= '0;
                lo   <= a;
            end
        end else if (busy_q) begin
            if (done) begin
                busy_q <= 1'b0;
            end
            if (!dz_q) begin
                hi    <= hi_n;
                lo    <= lo_n;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle add/sub/logic/slt, iterative mul/div with HI/LO results.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);

    state_t                state_q;
    state_t                state_n;

    logic                  in_ready_c;
    logic                  accept_c;
    logic                  load_c;
    logic                  start_c;
    md_mode_t              mode_c;
    logic [WIDTH-1:0]      res_n;
    logic [WIDTH-1:0]      hi_n;
    logic [STATUS_W-1:0]   st_n;

    logic [WIDTH-1:0]      op_a;
    logic [WIDTH-1:0]      op_b;
    logic [WIDTH:0]        sum_w;
    logic [WIDTH:0]        diff_w;
    logic [WIDTH-1:0]      sc_res;
    logic [STATUS_W-1:0]   sc_st;
    logic [STATUS_W-1:0]   md_st;

    logic                  it_done;
    logic [WIDTH-1:0]      it_hi;
    logic [WIDTH-1:0]      it_lo;

    logic                  md_mul_q;
    logic                  md_dz_q;
    logic                  out_valid_q;
    logic [WIDTH-1:0]      res_q;
    logic [WIDTH-1:0]      hi_q;
    logic [STATUS_W-1:0]   st_q;

    assign op_a = bus.alu_operand_1;
    assign op_b = bus.alu_operand_2;

    assign in_ready_c = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;

    assign bus.in_ready      = in_ready_c;
    assign bus.out_valid     = out_valid_q;
    assign bus.alu_result    = res_q;
    assign bus.alu_result_hi = hi_q;
    assign bus.alu_status    = st_q;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (start_c),
        .mode  (mode_c),
        .a     (op_a),
        .b     (op_b),
        .done  (it_done),
        .hi    (it_hi),
        .lo    (it_lo)
    );

    // Single-cycle datapath and flags; unknown opcodes fall through to add
    always_comb begin
        sum_w  = {1'b0, op_a} + {1'b0, op_b};
        diff_w = {1'b0, op_a} - {1'b0, op_b};
        sc_res = sum_w[WIDTH-1:0];
        sc_st  = '0;
        case (bus.alu_control)
            ALU_SUB: begin
                sc_res          = diff_w[WIDTH-1:0];
                sc_st[ST_CARRY] = diff_w[WIDTH];
                sc_st[ST_OVF]   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                                  (diff_w[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_AND:  sc_res = op_a & op_b;
            ALU_OR:   sc_res = op_a | op_b;
            ALU_SLT:  sc_res = WIDTH'($signed(op_a) < $signed(op_b));
            ALU_SLTU: sc_res = WIDTH'(op_a < op_b);
            default: begin
                sc_st[ST_CARRY] = sum_w[WIDTH];
                sc_st[ST_OVF]   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                  (sum_w[WIDTH-1] != op_a[WIDTH-1]);
            end
        endcase
        sc_st[ST_ZERO] = (sc_res == '0);
        sc_st[ST_NEG]  = sc_res[WIDTH-1];
    end

    always_comb begin
        md_st           = '0;
        md_st[ST_ZERO]  = (it_lo == '0) && (it_hi == '0);
        md_st[ST_NEG]   = it_lo[WIDTH-1];
        md_st[ST_CARRY] = md_mul_q && (it_hi != '0);
        md_st[ST_DZ]    = md_dz_q;
    end

    // Next-state and result-load control
    always_comb begin
        state_n = state_q;
        start_c = 1'b0;
        mode_c  = MODE_MUL;
        load_c  = 1'b0;
        res_n   = res_q;
        hi_n    = hi_q;
        st_n    = st_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (bus.alu_control == ALU_MUL) begin
                        start_c = 1'b1;
                        mode_c  = MODE_MUL;
                        state_n = MUL;
                    end else if (bus.alu_control == ALU_DIV) begin
                        start_c = 1'b1;
                        mode_c  = MODE_DIV;
                        state_n = DIV;
                    end else begin
                        load_c = 1'b1;
                        res_n  = sc_res;
                        hi_n   = '0;
                        st_n   = sc_st;
                    end
                end
            end
            MUL, DIV: begin
                if (it_done) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (!out_valid_q || bus.out_ready) begin
                    load_c  = 1'b1;
                    res_n   = it_lo;
                    hi_n    = it_hi;
                    st_n    = md_st;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Result registers only change when empty or being consumed on this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            hi_q        <= '0;
            st_q        <= '0;
            md_mul_q    <= 1'b0;
            md_dz_q     <= 1'b0;
        end else begin
            if (load_c) begin
                out_valid_q <= 1'b1;
                res_q       <= res_n;
                hi_q        <= hi_n;
                st_q        <= st_n;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept_c) begin
                md_mul_q <= (bus.alu_control == ALU_MUL);
                md_dz_q  <= (bus.alu_control == ALU_DIV) && (op_b == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32.
module tb_seq_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) bus();

    seq_alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid      = 1'b1;
        bus.alu_control   = op;
        bus.alu_operand_1 = a;
        bus.alu_operand_2 = b;
    endtask

    // Single-cycle op: result must be visible right after the accept edge
    task automatic sc(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] er, input logic [7:0] es);
        drive(op, a, b);
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_v"},   64'(bus.out_valid), 64'd1);
        chk({tag, "_res"}, 64'(bus.alu_result), 64'(er));
        chk({tag, "_hi"},  64'(bus.alu_result_hi), 64'd0);
        chk({tag, "_st"},  64'(bus.alu_status), 64'(es));
    endtask

    // Multi-cycle op: edges from accept to out_valid, and cycles with in_ready low
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy);
        drive(op, a, b);
        tick();
        bus.in_valid = 1'b0;
        lat  = 0;
        busy = 0;
        while (!bus.out_valid && lat < 200) begin
            if (!bus.in_ready) busy++;
            tick();
            lat++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int busy;
        int hold_bad;
        int stray;

        rst               = 1'b0;
        bus.in_valid      = 1'b0;
        bus.alu_control   = '0;
        bus.alu_operand_1 = '0;
        bus.alu_operand_2 = '0;
        bus.out_ready     = 1'b0;
        #2 rst = 1'b1;
        repeat (2) tick();

        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_res",   64'(bus.alu_result), 64'd0);
        chk("rst_hi",    64'(bus.alu_result_hi), 64'd0);
        chk("rst_st",    64'(bus.alu_status), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_rdy", 64'(bus.in_ready), 64'd1);

        bus.out_ready = 1'b1;
        sc("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 8'h0A);

        sc("sub_eq", ALU_SUB, 32'd5, 32'd5, 32'd0, 8'h01);
        chk("sub_rdy", 64'(bus.in_ready), 64'd1);
        sc("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 8'h00);
        chk("slt_rdy", 64'(bus.in_ready), 64'd1);

        sc("and",      ALU_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 8'h00);
        sc("or",       ALU_OR,   32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 8'h02);
        sc("sltu_t",   ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'd1, 8'h00);
        sc("sltu_f",   ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 8'h01);
        sc("slt_f",    ALU_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 8'h01);
        sc("sub_brw",  ALU_SUB,  32'd3, 32'd5, 32'hFFFF_FFFE, 8'h06);
        sc("sub_ovf",  ALU_SUB,  32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 8'h08);
        sc("add_cy",   ALU_ADD,  32'hFFFF_FFFF, 32'd1, 32'd0, 8'h05);
        sc("op_f",     4'b1111,  32'd2, 32'd3, 32'd5, 8'h00);
        sc("op_8",     4'b1000,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'h06);

        run_op(ALU_MUL, 32'hFFFF_FFFF, 32'h0000_0002, lat, busy);
        chk("mul_lat",  64'(lat), 64'd33);
        chk("mul_busy", 64'(busy), 64'd33);
        chk("mul_lo",   64'(bus.alu_result), 64'hFFFF_FFFE);
        chk("mul_hi",   64'(bus.alu_result_hi), 64'h0000_0001);
        chk("mul_st",   64'(bus.alu_status), 64'h06);

        run_op(ALU_DIV, 32'd100, 32'd7, lat, busy);
        chk("div_lat", 64'(lat), 64'd33);
        chk("div_q",   64'(bus.alu_result), 64'd14);
        chk("div_r",   64'(bus.alu_result_hi), 64'd2);
        chk("div_st",  64'(bus.alu_status), 64'h00);

        run_op(ALU_DIV, 32'd9, 32'd0, lat, busy);
        chk("dz_lat", 64'(lat), 64'd2);
        chk("dz_q",   64'(bus.alu_result), 64'hFFFF_FFFF);
        chk("dz_r",   64'(bus.alu_result_hi), 64'd9);
        chk("dz_st",  64'(bus.alu_status), 64'h12);

        tick();
        chk("drain", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;
        drive(ALU_ADD, 32'd3, 32'd4);
        tick();
        drive(ALU_OR, 32'h10, 32'h01);
        hold_bad = 0;
        repeat (5) begin
            if (!bus.out_valid || bus.alu_result !== 32'd7 || bus.in_ready) hold_bad++;
            tick();
        end
        chk("bp_hold", 64'(hold_bad), 64'd0);
        chk("bp_res",  64'(bus.alu_result), 64'd7);
        chk("bp_st",   64'(bus.alu_status), 64'h00);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rdy", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_next_v",   64'(bus.out_valid), 64'd1);
        chk("bp_next_res", 64'(bus.alu_result), 64'h11);

        drive(ALU_MUL, 32'h1234_5678, 32'd3);
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_v",   64'(bus.out_valid), 64'd0);
        chk("mid_rst_res", 64'(bus.alu_result), 64'd0);
        chk("mid_rst_hi",  64'(bus.alu_result_hi), 64'd0);
        chk("mid_rst_st",  64'(bus.alu_status), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", 64'(bus.in_ready), 64'd1);
        stray = 0;
        repeat (40) begin
            tick();
            if (bus.out_valid) stray++;
        end
        chk("no_partial", 64'(stray), 64'd0);
        sc("post_rst_add", ALU_ADD, 32'd1, 32'd1, 32'd2, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
